// File: rtl/cpu_step_display.sv
// Single-step clock generator for the multicycle CPU: debounced push-button stepping,
// snapshot of selected datapath bytes, and a 4-digit multiplexed hex display.
module cpu_step_display #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SCAN_CYCLES     = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BTN_STEP,
    input  logic [1:0]  SW_SEL,
    input  logic [31:0] PC_CUR,
    input  logic [31:0] PC_NEXT,
    input  logic [4:0]  RS_ADDR,
    input  logic [31:0] RS_DATA,
    input  logic [4:0]  RT_ADDR,
    input  logic [31:0] RT_DATA,
    input  logic [31:0] ALU_RESULT,
    input  logic [31:0] DB_DATA,
    output logic        CPU_CLK,
    output logic [15:0] STEP_COUNT,
    output logic [3:0]  AN,
    output logic [7:0]  SEG
);

    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SC_W    = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned PAGES   = 4;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned DIGIT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic                          r_btn_meta;
    logic                          r_btn_s;
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [DB_W-1:0]               r_db_cnt;
    logic [DB_W-1:0]               w_db_cnt_nxt;
    logic                          w_db_done;
    logic                          r_cpu_clk;
    logic                          w_cpu_clk_nxt;
    logic                          w_step_done;
    logic [15:0]                   r_step_count;
    logic                          r_load_pulse;
    logic                          r_load_flag;
    logic                          w_load;
    logic [PAGES-1:0][WORD_W-1:0]  r_snap;
    logic [PAGES-1:0][WORD_W-1:0]  w_snap_in;
    logic [SC_W-1:0]               r_scan_cnt;
    logic                          w_scan_wrap;
    logic [DIGIT_W-1:0]            r_digit;
    logic [WORD_W-1:0]             w_page_word;
    logic [3:0]                    w_nibble;
    logic [7:0]                    w_seg_font;
    logic [3:0]                    r_an;
    logic [7:0]                    r_seg;
    logic                          w_unused;

    // Upper datapath bits are never displayed.
    assign w_unused = &{1'b0, PC_CUR[31:8], PC_NEXT[31:8], RS_DATA[31:8], RT_DATA[31:8],
                        ALU_RESULT[31:8], DB_DATA[31:8]};

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_btn_meta <= BTN_STEP;
            r_btn_s    <= r_btn_meta;
        end
    end

    // Terminal count: this is the DEBOUNCE_CYCLES-th consecutive stable sample.
    assign w_db_done = (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 2));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = S_PRESS_WAIT;
                end
            end
            S_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_IDLE;
                end else if (w_db_done) begin
                    w_state_nxt = S_HELD;
                end
            end
            S_HELD: begin
                if (!r_btn_s) begin
                    w_state_nxt = S_RELEASE_WAIT;
                end
            end
            S_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    w_state_nxt = S_HELD;
                end else if (w_db_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_db_cnt_nxt  = r_db_cnt;
        w_cpu_clk_nxt = r_cpu_clk;
        w_step_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_db_cnt_nxt  = '0;
                w_cpu_clk_nxt = 1'b0;
            end
            S_PRESS_WAIT: begin
                if (!r_btn_s) begin
                    w_db_cnt_nxt = '0;
                end else if (w_db_done) begin
                    w_db_cnt_nxt  = '0;
                    w_cpu_clk_nxt = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            S_HELD: begin
                w_db_cnt_nxt  = '0;
                w_cpu_clk_nxt = 1'b1;
            end
            S_RELEASE_WAIT: begin
                if (r_btn_s) begin
                    w_db_cnt_nxt = '0;
                end else if (w_db_done) begin
                    w_db_cnt_nxt  = '0;
                    w_cpu_clk_nxt = 1'b0;
                    w_step_done   = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_db_cnt_nxt  = '0;
                w_cpu_clk_nxt = 1'b0;
            end
        endcase
    end

    // Stepped clock, step counter and the release-accept load pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_db_cnt     <= '0;
            r_cpu_clk    <= 1'b0;
            r_step_count <= 16'h0000;
            r_load_pulse <= 1'b0;
        end else begin
            r_db_cnt     <= w_db_cnt_nxt;
            r_cpu_clk    <= w_cpu_clk_nxt;
            r_load_pulse <= w_step_done;
            if (w_step_done) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

    assign w_load = r_load_flag | r_load_pulse;

    // Page words are {left byte, right byte}.
    assign w_snap_in[0] = {PC_CUR[7:0], PC_NEXT[7:0]};
    assign w_snap_in[1] = {3'b000, RS_ADDR, RS_DATA[7:0]};
    assign w_snap_in[2] = {3'b000, RT_ADDR, RT_DATA[7:0]};
    assign w_snap_in[3] = {ALU_RESULT[7:0], DB_DATA[7:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_load_flag <= 1'b1;
            r_snap      <= '0;
        end else begin
            r_load_flag <= 1'b0;
            if (w_load) begin
                r_snap <= w_snap_in;
            end
        end
    end

    assign w_scan_wrap = (r_scan_cnt == SC_W'(SCAN_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + DIGIT_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SC_W'(1);
        end
    end

    // Page select is applied live so a switch change needs no reload.
    assign w_page_word = r_snap[SW_SEL];

    always_comb begin
        w_nibble = w_page_word[3:0];
        case (r_digit)
            2'd0: w_nibble = w_page_word[3:0];
            2'd1: w_nibble = w_page_word[7:4];
            2'd2: w_nibble = w_page_word[11:8];
            2'd3: w_nibble = w_page_word[15:12];
            default: w_nibble = w_page_word[3:0];
        endcase
    end

    // Active-low font with dp held off.
    always_comb begin
        w_seg_font = 8'hFF;
        case (w_nibble)
            4'h0: w_seg_font = 8'hC0;
            4'h1: w_seg_font = 8'hF9;
            4'h2: w_seg_font = 8'hA4;
            4'h3: w_seg_font = 8'hB0;
            4'h4: w_seg_font = 8'h99;
            4'h5: w_seg_font = 8'h92;
            4'h6: w_seg_font = 8'h82;
            4'h7: w_seg_font = 8'hF8;
            4'h8: w_seg_font = 8'h80;
            4'h9: w_seg_font = 8'h90;
            4'hA: w_seg_font = 8'h88;
            4'hB: w_seg_font = 8'h83;
            4'hC: w_seg_font = 8'hC6;
            4'hD: w_seg_font = 8'hA1;
            4'hE: w_seg_font = 8'h86;
            4'hF: w_seg_font = 8'h8E;
            default: w_seg_font = 8'hFF;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_font;
        end
    end

    assign CPU_CLK    = r_cpu_clk;
    assign STEP_COUNT = r_step_count;
    assign AN         = r_an;
    assign SEG        = r_seg;

endmodule

// File: tb/tb_cpu_step_display.sv
// Directed bench for cpu_step_display with DEBOUNCE_CYCLES=4 and SCAN_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_cpu_step_display;

    logic        CLK;
    logic        RST;
    logic        BTN_STEP;
    logic [1:0]  SW_SEL;
    logic [31:0] PC_CUR;
    logic [31:0] PC_NEXT;
    logic [4:0]  RS_ADDR;
    logic [31:0] RS_DATA;
    logic [4:0]  RT_ADDR;
    logic [31:0] RT_DATA;
    logic [31:0] ALU_RESULT;
    logic [31:0] DB_DATA;
    logic        CPU_CLK;
    logic [15:0] STEP_COUNT;
    logic [3:0]  AN;
    logic [7:0]  SEG;

    int n_checks = 0;
    int n_fails  = 0;
    int rises    = 0;
    int rises0   = 0;
    int n        = 0;
    logic prev_clk = 1'b0;

    cpu_step_display #(
        .DEBOUNCE_CYCLES(4),
        .SCAN_CYCLES(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN_STEP(BTN_STEP),
        .SW_SEL(SW_SEL),
        .PC_CUR(PC_CUR),
        .PC_NEXT(PC_NEXT),
        .RS_ADDR(RS_ADDR),
        .RS_DATA(RS_DATA),
        .RT_ADDR(RT_ADDR),
        .RT_DATA(RT_DATA),
        .ALU_RESULT(ALU_RESULT),
        .DB_DATA(DB_DATA),
        .CPU_CLK(CPU_CLK),
        .STEP_COUNT(STEP_COUNT),
        .AN(AN),
        .SEG(SEG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, counting CPU_CLK rising edges.
    task automatic tick(input int cnt);
        repeat (cnt) begin
            @(posedge CLK);
            #1;
            if (CPU_CLK === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = CPU_CLK;
        end
    endtask

    task automatic wait_an(input logic [3:0] want, output int cycles);
        cycles = 0;
        while (AN !== want && cycles < 64) begin
            tick(1);
            cycles++;
        end
        check("an_reached", 32'(AN), 32'(want));
    endtask

    // Full press/release from IDLE with the exact edge timing checked.
    task automatic do_step(input logic [15:0] exp_count);
        BTN_STEP = 1'b1;
        tick(5);
        check("cpu_clk_before_rise", 32'(CPU_CLK), 32'd0);
        tick(1);
        check("cpu_clk_rise", 32'(CPU_CLK), 32'd1);
        tick(4);
        BTN_STEP = 1'b0;
        tick(5);
        check("cpu_clk_before_fall", 32'(CPU_CLK), 32'd1);
        tick(1);
        check("cpu_clk_fall", 32'(CPU_CLK), 32'd0);
        check("step_count", 32'(STEP_COUNT), 32'(exp_count));
        tick(2);
    endtask

    initial begin
        RST        = 1'b1;
        BTN_STEP   = 1'b0;
        SW_SEL     = 2'b00;
        PC_CUR     = 32'h0000_0004;
        PC_NEXT    = 32'h0000_0008;
        RS_ADDR    = 5'd0;
        RS_DATA    = 32'h0;
        RT_ADDR    = 5'd0;
        RT_DATA    = 32'h0;
        ALU_RESULT = 32'h0;
        DB_DATA    = 32'h0;
        tick(2);
        check("rst_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("rst_step_count", 32'(STEP_COUNT), 32'd0);
        check("rst_an", 32'(AN), 32'hF);
        check("rst_seg", 32'(SEG), 32'hFF);

        // Page 00 scan after the post-reset load.
        RST = 1'b0;
        tick(2);
        check("p0_d0_an", 32'(AN), 32'hE);
        check("p0_d0_seg", 32'(SEG), 32'h80);
        PC_CUR = 32'h0000_00AB;
        wait_an(4'b1101, n);
        check("p0_d1_seg", 32'(SEG), 32'hC0);
        wait_an(4'b1011, n);
        check("scan_period", 32'(n), 32'd8);
        check("p0_d2_seg_no_reload", 32'(SEG), 32'h99);
        wait_an(4'b0111, n);
        check("scan_period_2", 32'(n), 32'd8);
        check("p0_d3_seg_no_reload", 32'(SEG), 32'hC0);

        // One step reloads the snapshot with the new PC_CUR.
        do_step(16'd1);
        wait_an(4'b1011, n);
        check("p0_d2_after_step", 32'(SEG), 32'h83);
        wait_an(4'b0111, n);
        check("p0_d3_after_step", 32'(SEG), 32'h88);

        // Short pulses never reach the debounce count.
        rises0 = rises;
        for (int i = 0; i < 5; i++) begin
            BTN_STEP = 1'b1;
            tick(2);
            BTN_STEP = 1'b0;
            tick(3);
        end
        tick(6);
        check("glitch_rises", 32'(rises - rises0), 32'd0);
        check("glitch_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("glitch_step_count", 32'(STEP_COUNT), 32'd1);

        // Short low glitch while held gives a single step.
        rises0 = rises;
        BTN_STEP = 1'b1;
        tick(10);
        check("held_cpu_clk", 32'(CPU_CLK), 32'd1);
        BTN_STEP = 1'b0;
        tick(2);
        BTN_STEP = 1'b1;
        tick(8);
        check("held_after_glitch", 32'(CPU_CLK), 32'd1);
        BTN_STEP = 1'b0;
        tick(12);
        check("held_glitch_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("held_glitch_rises", 32'(rises - rises0), 32'd1);
        check("held_glitch_step_count", 32'(STEP_COUNT), 32'd2);

        // Register pages.
        SW_SEL     = 2'b01;
        RS_ADDR    = 5'd17;
        RS_DATA    = 32'h1234_563C;
        RT_ADDR    = 5'd31;
        RT_DATA    = 32'hFFFF_FF90;
        ALU_RESULT = 32'h0000_005E;
        DB_DATA    = 32'hABCD_00D7;
        do_step(16'd3);
        wait_an(4'b0111, n);
        check("p1_d3", 32'(SEG), 32'hF9);
        wait_an(4'b1110, n);
        check("p1_d0", 32'(SEG), 32'hC6);
        wait_an(4'b1101, n);
        check("p1_d1", 32'(SEG), 32'hB0);
        wait_an(4'b1011, n);
        check("p1_d2", 32'(SEG), 32'hF9);

        SW_SEL = 2'b11;
        tick(1);
        wait_an(4'b0111, n);
        check("p3_d3", 32'(SEG), 32'h92);
        wait_an(4'b1110, n);
        check("p3_d0", 32'(SEG), 32'hF8);
        wait_an(4'b1101, n);
        check("p3_d1", 32'(SEG), 32'hA1);
        SW_SEL = 2'b10;
        tick(1);
        check("p2_d1_live", 32'(SEG), 32'h90);
        wait_an(4'b1011, n);
        check("p2_d2", 32'(SEG), 32'h8E);

        // Reset while the stepped clock is high.
        BTN_STEP = 1'b1;
        tick(8);
        check("pre_rst_cpu_clk", 32'(CPU_CLK), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("mid_rst_an", 32'(AN), 32'hF);
        check("mid_rst_seg", 32'(SEG), 32'hFF);
        check("mid_rst_step_count", 32'(STEP_COUNT), 32'd0);
        tick(1);
        RST = 1'b0;
        tick(5);
        check("held_after_rst_wait", 32'(CPU_CLK), 32'd0);
        tick(1);
        check("held_after_rst_rise", 32'(CPU_CLK), 32'd1);
        BTN_STEP = 1'b0;
        tick(12);
        check("after_rst_cpu_clk", 32'(CPU_CLK), 32'd0);
        check("after_rst_step_count", 32'(STEP_COUNT), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
